tc_timer: RTL and testbench

Memory-mapped countdown timer on the processor's external device bus, downstream of the CPU core's `PrAddr`/`PrWD`/`PrWe` port via the system bridge. It holds three 32-bit registers (CTRL, PRESET, COUNT), counts down on every clock while enabled, and raises an interrupt request that the bridge routes onto one `HWInt` line of the core. A four-state FSM governs load, count and interrupt; one-shot and auto-reload modes are supported.

---
 rtl/tc_timer_if.sv | 14 +
 rtl/tc_timer.sv | 179 +++++++++++++++++
 tb/tb_tc_timer.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/tc_timer_if.sv
// tc_timer_if: register-bus port bundle between the system bridge and tc_timer.
interface tc_timer_if;
  localparam int unsigned AW = 2;
  localparam int unsigned DW = 32;

  logic [AW-1:0] addr;
  logic          we;
  logic [DW-1:0] din;
  logic [DW-1:0] dout;
  logic          irq;

  modport master (output addr, we, din, input dout, irq);
  modport slave  (input addr, we, din, output dout, irq);
endinterface

// File: rtl/tc_timer.sv
// tc_timer: memory-mapped countdown timer (CTRL/PRESET/COUNT) with interrupt.
// Optional feature macro: TC_TIMER_AUTORELOAD_EN (stores CTRL.Mode, enables
// Mode 01 auto-reload). Without it every mode is one-shot.
module tc_timer (
  input  logic       clk,
  input  logic       reset,
  tc_timer_if.slave  bus
);
  localparam int unsigned DW = 32;

  localparam logic [1:0] A_CTRL   = 2'd0;
  localparam logic [1:0] A_PRESET = 2'd1;
  localparam logic [1:0] A_COUNT  = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_CNT  = 2'd2,
    S_INT  = 2'd3
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;

  logic          r_en;
  logic          r_im;
  logic [1:0]    w_mode;
  logic [DW-1:0] r_preset;
  logic [DW-1:0] r_count;
  logic          r_irq_flag;

  logic          w_wr_ctrl;
  logic          w_wr_preset;
  logic          w_autoreload;

  logic          w_load;
  logic          w_dec;
  logic          w_to_zero;
  logic          w_set_flag;
  logic          w_clr_en;
  logic          w_clr_flag_ar;

  assign w_wr_ctrl   = bus.we && (bus.addr == A_CTRL);
  assign w_wr_preset = bus.we && (bus.addr == A_PRESET);

`ifdef TC_TIMER_AUTORELOAD_EN
  logic [1:0] r_mode;

  // Mode field storage (only present with auto-reload support)
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mode <= 2'b00;
    end else if (w_wr_ctrl) begin
      r_mode <= bus.din[2:1];
    end
  end

  assign w_mode       = r_mode;
  assign w_autoreload = (r_mode == 2'b01);
`else
  assign w_mode       = 2'b00;
  assign w_autoreload = 1'b0;
`endif

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (r_en) w_state_nxt = S_LOAD;
      S_LOAD: w_state_nxt = S_CNT;
      S_CNT: begin
        if (!r_en) begin
          w_state_nxt = S_IDLE;
        end else if (r_count <= DW'(1)) begin
          w_state_nxt = S_INT;
        end
      end
      S_INT: begin
`ifdef TC_TIMER_AUTORELOAD_EN
        w_state_nxt = w_autoreload ? S_LOAD : S_IDLE;
`else
        w_state_nxt = S_IDLE;
`endif
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // FSM datapath controls decoded from the current state
  always_comb begin
    w_load        = 1'b0;
    w_dec         = 1'b0;
    w_to_zero     = 1'b0;
    w_set_flag    = 1'b0;
    w_clr_en      = 1'b0;
    w_clr_flag_ar = 1'b0;
    case (r_state)
      S_LOAD: begin
        w_load        = 1'b1;
        w_clr_flag_ar = w_autoreload;
      end
      S_CNT: begin
        if (r_en) begin
          if (r_count <= DW'(1)) begin
            w_to_zero = 1'b1;
          end else begin
            w_dec = 1'b1;
          end
        end
      end
      S_INT: begin
        w_set_flag = 1'b1;
        w_clr_en   = !w_autoreload;
      end
      default: ;
    endcase
  end

  // Register file and counter; a CPU CTRL write overrides FSM side effects
  always_ff @(posedge clk) begin
    if (reset) begin
      r_en       <= 1'b0;
      r_im       <= 1'b0;
      r_preset   <= '0;
      r_count    <= '0;
      r_irq_flag <= 1'b0;
    end else begin
      if (w_load) begin
        r_count <= r_preset;
      end else if (w_to_zero) begin
        r_count <= '0;
      end else if (w_dec) begin
        r_count <= r_count - DW'(1);
      end

      if (w_wr_ctrl) begin
        r_en <= bus.din[0];
        r_im <= bus.din[3];
      end else if (w_clr_en) begin
        r_en <= 1'b0;
      end

      if (w_wr_ctrl) begin
        r_irq_flag <= 1'b0;
      end else if (w_set_flag) begin
        r_irq_flag <= 1'b1;
      end else if (w_clr_flag_ar) begin
        r_irq_flag <= 1'b0;
      end

      if (w_wr_preset) begin
        r_preset <= bus.din;
      end
    end
  end

  // Zero-latency read mux
  always_comb begin
    bus.dout = '0;
    case (bus.addr)
      A_CTRL:   bus.dout = {28'd0, r_im, w_mode, r_en};
      A_PRESET: bus.dout = r_preset;
      A_COUNT:  bus.dout = r_count;
      default:  bus.dout = '0;
    endcase
  end

  assign bus.irq = r_irq_flag & r_im;

endmodule

// File: tb/tb_tc_timer.sv
// tb_tc_timer: directed + random stimulus, elapsed-time reference model,
// queue-based scoreboard comparing dout/irq every cycle.
module tb_tc_timer;
  logic clk = 1'b0;
  logic reset;

  tc_timer_if bus_if ();

  tc_timer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [32:0] exp_q[$];

  // Reference model: a running timer is described by the number of edges
  // elapsed since it entered its load cycle.
  logic        m_en, m_im, m_flag, m_run;
  logic [1:0]  m_mode;
  logic [31:0] m_preset, m_count, m_pload;
  longint      m_age, m_pl;

  function automatic logic m_ar();
`ifdef TC_TIMER_AUTORELOAD_EN
    return m_mode == 2'b01;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] m_dout(input logic [1:0] a);
    case (a)
      2'd0:    return {28'd0, m_im, m_mode, m_en};
      2'd1:    return m_preset;
      2'd2:    return m_count;
      default: return 32'd0;
    endcase
  endfunction

  task automatic m_clear();
    m_en = 0; m_im = 0; m_flag = 0; m_run = 0; m_mode = 2'b00;
    m_preset = 0; m_count = 0; m_pload = 0; m_age = 0; m_pl = 1;
  endtask

  task automatic model_edge(input logic rst, input logic w,
                            input logic [1:0] a, input logic [31:0] d);
    logic ar;
    if (rst) begin
      m_clear();
      return;
    end
    ar = m_ar();
    if (!m_run) begin
      if (m_en) begin
        m_run = 1; m_age = 0;
      end
    end else if (m_age == 0) begin
      m_pload = m_preset;
      m_pl    = (m_preset == 0) ? 1 : longint'(m_preset);
      m_count = m_preset;
      if (ar) m_flag = 0;
      m_age = 1;
    end else if (m_age <= m_pl) begin
      if (!m_en) begin
        m_run = 0;
      end else begin
        m_count = (longint'(m_pload) > m_age) ? 32'(longint'(m_pload) - m_age) : 32'd0;
        m_age++;
      end
    end else begin
      m_flag = 1;
      if (ar) begin
        m_age = 0;
      end else begin
        m_en = 0; m_run = 0;
      end
    end
    if (w && a == 2'd0) begin
      m_en = d[0];
      m_im = d[3];
`ifdef TC_TIMER_AUTORELOAD_EN
      m_mode = d[2:1];
`endif
      m_flag = 0;
    end
    if (w && a == 2'd1) m_preset = d;
  endtask

  // One bus cycle: drive, record expectation, then advance the model
  task automatic cyc(input logic rst, input logic w,
                     input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    reset = rst; bus_if.we = w; bus_if.addr = a; bus_if.din = d;
    #1;
    exp_q.push_back({m_flag & m_im, m_dout(a)});
    @(posedge clk);
    model_edge(rst, w, a, d);
  endtask

  task automatic rd(input logic [1:0] a);
    cyc(1'b0, 1'b0, a, 32'd0);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    cyc(1'b0, 1'b1, a, d);
  endtask

  task automatic wait_count(input logic [31:0] v);
    for (int i = 0; i < 60 && m_count != v; i++) rd(2'd2);
    if (m_count != v) begin
      n_cmp++; n_bad++;
      $display("FAIL wait_count: model COUNT %0d never reached %0d", m_count, v);
    end
  endtask

  // Monitor: compare DUT outputs mid low-phase against queued expectations
  initial begin
    logic [32:0] e;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_cmp++;
        if (bus_if.dout !== e[31:0]) begin
          n_bad++;
          $display("FAIL dout t=%0t addr=%0d got=0x%08h exp=0x%08h",
                   $time, bus_if.addr, bus_if.dout, e[31:0]);
        end
        n_cmp++;
        if (bus_if.irq !== e[32]) begin
          n_bad++;
          $display("FAIL irq t=%0t got=%0b exp=%0b", $time, bus_if.irq, e[32]);
        end
      end
    end
  end

  initial begin
    int r;
    logic [1:0] a;
    logic [31:0] d;
    m_clear();
    reset = 1'b1; bus_if.we = 1'b0; bus_if.addr = 2'd0; bus_if.din = 32'd0;

    // Reset and read-back of all offsets; COUNT is read-only
    cyc(1'b1, 1'b0, 2'd0, 32'd0);
    cyc(1'b1, 1'b0, 2'd0, 32'd0);
    for (int i = 0; i < 4; i++) rd(2'(i));
    wr(2'd2, 32'h55);
    rd(2'd2);
    wr(2'd3, 32'hdead_beef);
    rd(2'd3);

    // One-shot, PRESET=5
    wr(2'd1, 32'd5);
    wr(2'd0, 32'h9);
    for (int i = 0; i < 12; i++) rd(2'd2);
    rd(2'd0);
    wr(2'd0, 32'h8);
    rd(2'd0); rd(2'd0);

    // Auto-reload request, PRESET=3
    wr(2'd1, 32'd3);
    wr(2'd0, 32'hB);
    for (int i = 0; i < 22; i++) rd(2'((i % 7 == 6) ? 0 : 2));
    wr(2'd0, 32'h0);
    rd(2'd0);

    // Disable mid-count, hold, then re-enable
    cyc(1'b1, 1'b0, 2'd0, 32'd0);
    wr(2'd1, 32'd10);
    wr(2'd0, 32'h9);
    wait_count(32'd6);
    wr(2'd0, 32'h8);
    for (int i = 0; i < 10; i++) rd(2'd2);
    wr(2'd0, 32'h9);
    for (int i = 0; i < 16; i++) rd(2'd2);

    // PRESET=0 behaves as PRESET=1
    cyc(1'b1, 1'b0, 2'd0, 32'd0);
    wr(2'd0, 32'h9);
    for (int i = 0; i < 8; i++) rd(2'd2);

    // Reset mid-count
    cyc(1'b1, 1'b0, 2'd0, 32'd0);
    wr(2'd1, 32'd6);
    wr(2'd0, 32'h9);
    wait_count(32'd3);
    cyc(1'b1, 1'b0, 2'd2, 32'd0);
    for (int i = 0; i < 4; i++) rd(2'(i));
    rd(2'd2); rd(2'd2);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 99);
      a = 2'($urandom_range(0, 3));
      if (r == 0) begin
        cyc(1'b1, 1'b0, a, 32'd0);
      end else if (r < 14) begin
        d = (a == 2'd1) ? 32'($urandom_range(0, 12)) : $urandom;
        wr(a, d);
      end else begin
        rd(a);
      end
    end

    rd(2'd0); rd(2'd2);
    @(negedge clk);
    #3;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left, exp 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
